// File: rtl/ped_pkg.sv
// Shared types and defaults for the pedestrian crossing controller.
// Countdown output is built only with PED_COUNTDOWN_EN defined.
package ped_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RED,
        WALK,
        FLASH,
        CLEAR,
        FAULT
    } state_t;

    localparam int WALKTIMER_DEF  = 4;
    localparam int FLASHTIMER_DEF = 3;
    localparam int TIMER_W        = 4;

    // More than one vehicle lamp lit at once is an upstream fault.
    function automatic logic lamp_illegal(
        input logic r,
        input logic y,
        input logic g
    );
        return (r & y) | (r & g) | (y & g);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: registers the previous input level.
// Used on the vehicle red lamp to find the start of each red phase.
module rise_detect (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = d;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = d & ~prev_q;

endmodule

// File: rtl/ped_crossing.sv
// Pedestrian crossing controller slaved to a vehicle traffic light.
// Define PED_COUNTDOWN_EN to drive the flash countdown output.
module ped_crossing
    import ped_pkg::*;
#(
    parameter int WALKTIMER  = WALKTIMER_DEF,
    parameter int FLASHTIMER = FLASHTIMER_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       red,
    input  logic       yellow,
    input  logic       green,
    input  logic       ped_btn,
    output logic       walk,
    output logic       dont_walk,
    output logic       req_pending,
    output logic       fault,
    output logic [3:0] countdown
);

    localparam logic [TIMER_W-1:0] WALK_LAST  = TIMER_W'(WALKTIMER - 1);
    localparam logic [TIMER_W-1:0] FLASH_LAST = TIMER_W'(FLASHTIMER - 1);
    localparam logic [TIMER_W-1:0] FLASH_LEN  = TIMER_W'(FLASHTIMER);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               req_q, req_d;
    logic               walk_q, walk_d;
    logic               dont_walk_q, dont_walk_d;
    logic               fault_q, fault_d;
    logic [3:0]         countdown_q, countdown_d;
    logic               red_rise;
    logic               illegal;
    logic               timed;

    rise_detect u_red_rise (
        .clk  (clk),
        .rstn (rstn),
        .d    (red),
        .rise (red_rise)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        illegal = lamp_illegal(red, yellow, green);

        if (state_q == FAULT || illegal) begin
            state_d = FAULT;
        end else begin
            if (state_q != WALK && ped_btn) begin
                req_d = 1'b1;
            end
            unique case (state_q)
                IDLE, WAIT_RED: begin
                    if (red_rise && (req_q || ped_btn)) begin
                        state_d = WALK;
                    end else if (state_q == IDLE && req_q) begin
                        state_d = WAIT_RED;
                    end
                end
                WALK: begin
                    if (!red) begin
                        state_d = IDLE;
                    end else if (timer_q == WALK_LAST) begin
                        state_d = FLASH;
                    end
                end
                FLASH: begin
                    if (!red) begin
                        state_d = IDLE;
                    end else if (timer_q == FLASH_LAST) begin
                        state_d = CLEAR;
                    end
                end
                CLEAR: begin
                    // Only one walk per red phase: wait for red to end.
                    if (!red) begin
                        state_d = req_q ? WAIT_RED : IDLE;
                    end
                end
                default: begin
                end
            endcase
            if (state_d == WALK && state_q != WALK) begin
                req_d = 1'b0;
            end
        end

        timed = (state_q == WALK) || (state_q == FLASH);
        if (state_d != state_q || !timed) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        // Outputs are precomputed from the next state so they are flops.
        walk_d  = (state_d == WALK);
        fault_d = (state_d == FAULT);
        if (state_d == FLASH) begin
            dont_walk_d = ~timer_d[0];
        end else begin
            dont_walk_d = (state_d != WALK);
        end
`ifdef PED_COUNTDOWN_EN
        if (state_d == FLASH) begin
            countdown_d = FLASH_LEN - timer_d;
        end else begin
            countdown_d = 4'd0;
        end
`else
        countdown_d = 4'd0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            req_q       <= 1'b0;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            fault_q     <= 1'b0;
            countdown_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            req_q       <= req_d;
            walk_q      <= walk_d;
            dont_walk_q <= dont_walk_d;
            fault_q     <= fault_d;
            countdown_q <= countdown_d;
        end
    end

    assign walk        = walk_q;
    assign dont_walk   = dont_walk_q;
    assign req_pending = req_q;
    assign fault       = fault_q;
    assign countdown   = countdown_q;

endmodule

// File: tb/tb_ped_crossing.sv
// Bench for ped_crossing: directed scenarios plus randomized light
// sequences, compared every cycle against a phase/counter model.
module tb_ped_crossing;

    localparam int WT = 4;
    localparam int FT = 3;

    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_WALK  = 2;
    localparam int M_FLASH = 3;
    localparam int M_CLEAR = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic       red;
    logic       yellow;
    logic       green;
    logic       ped_btn;
    logic       walk;
    logic       dont_walk;
    logic       req_pending;
    logic       fault;
    logic [3:0] countdown;

    int checks = 0;
    int errors = 0;

    int m_ph;
    int m_walk_left;
    int m_flash_left;
    bit m_req;
    bit m_flt;
    bit m_prev_red;

    ped_crossing #(
        .WALKTIMER  (WT),
        .FLASHTIMER (FT)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .red         (red),
        .yellow      (yellow),
        .green       (green),
        .ped_btn     (ped_btn),
        .walk        (walk),
        .dont_walk   (dont_walk),
        .req_pending (req_pending),
        .fault       (fault),
        .countdown   (countdown)
    );

    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of behaviour, from the sampled inputs.
    task automatic model_step();
        bit rise;
        bit old_req;
        if (!rstn) begin
            m_ph = M_IDLE;
            m_req = 0;
            m_flt = 0;
            m_prev_red = 0;
            m_walk_left = 0;
            m_flash_left = 0;
            return;
        end
        rise = red && !m_prev_red;
        m_prev_red = red;
        if (m_flt) return;
        if (int'(red) + int'(yellow) + int'(green) > 1) begin
            m_flt = 1;
            return;
        end
        old_req = m_req;
        if (m_ph != M_WALK && ped_btn) m_req = 1;
        case (m_ph)
            M_IDLE, M_WAIT: begin
                if (rise && (old_req || ped_btn)) begin
                    m_ph = M_WALK;
                    m_walk_left = WT;
                    m_req = 0;
                end else if (m_ph == M_IDLE && old_req) begin
                    m_ph = M_WAIT;
                end
            end
            M_WALK: begin
                if (!red) m_ph = M_IDLE;
                else begin
                    m_walk_left--;
                    if (m_walk_left == 0) begin
                        m_ph = M_FLASH;
                        m_flash_left = FT;
                    end
                end
            end
            M_FLASH: begin
                if (!red) m_ph = M_IDLE;
                else begin
                    m_flash_left--;
                    if (m_flash_left == 0) m_ph = M_CLEAR;
                end
            end
            default: begin
                if (!red) m_ph = old_req ? M_WAIT : M_IDLE;
            end
        endcase
    endtask

    task automatic compare();
        bit e_walk;
        bit e_dw;
        int e_cd;
        e_walk = !m_flt && m_ph == M_WALK;
        if (m_flt) e_dw = 1;
        else if (m_ph == M_FLASH) e_dw = ((FT - m_flash_left) % 2) == 0;
        else e_dw = (m_ph != M_WALK);
        e_cd = 0;
`ifdef PED_COUNTDOWN_EN
        if (!m_flt && m_ph == M_FLASH) e_cd = m_flash_left;
`endif
        chk("walk", 32'(walk), 32'(e_walk));
        chk("dont_walk", 32'(dont_walk), 32'(e_dw));
        chk("req_pending", 32'(req_pending), 32'(m_req));
        chk("fault", 32'(fault), 32'(m_flt));
        chk("countdown", 32'(countdown), 32'(e_cd));
    endtask

    task automatic cyc(
        input bit r,
        input bit y,
        input bit g,
        input bit b,
        input bit rn = 1'b1
    );
        rstn = rn;
        red = r;
        yellow = y;
        green = g;
        ped_btn = b;
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    function automatic bit rbtn();
        return $urandom_range(0, 3) == 0;
    endfunction

    initial begin
        m_ph = M_IDLE;
        m_req = 0;
        m_flt = 0;
        m_prev_red = 0;
        m_walk_left = 0;
        m_flash_left = 0;

        // Reset and fixed reset values.
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        chk("rst_walk", 32'(walk), 32'd0);
        chk("rst_dont_walk", 32'(dont_walk), 32'd1);
        chk("rst_req", 32'(req_pending), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_countdown", 32'(countdown), 32'd0);

        // Request on green, full walk/flash/clear at next red.
        cyc(0, 0, 1, 1);
        chk("req_latched", 32'(req_pending), 32'd1);
        repeat (2) cyc(0, 0, 1, 0);
        repeat (2) cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("walk_at_rise", 32'(walk), 32'd1);
        repeat (11) cyc(1, 0, 0, 0);
        repeat (3) cyc(0, 0, 1, 0);

        // Button coinciding with the red rise from idle.
        cyc(1, 0, 0, 1);
        chk("same_cycle_walk", 32'(walk), 32'd1);
        chk("same_cycle_req", 32'(req_pending), 32'd0);
        repeat (9) cyc(1, 0, 0, 0);
        repeat (3) cyc(0, 0, 1, 0);

        // Red drops during the second walk cycle.
        cyc(0, 0, 1, 1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        chk("abort_walk", 32'(walk), 32'd0);
        chk("abort_dw", 32'(dont_walk), 32'd1);
        repeat (2) cyc(0, 0, 1, 0);

        // Button during flash: no second walk until next red.
        cyc(1, 0, 0, 1);
        repeat (4) cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        repeat (6) cyc(1, 0, 0, 0);
        chk("no_second_walk", 32'(walk), 32'd0);
        repeat (3) cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk("walk_next_red", 32'(walk), 32'd1);
        repeat (9) cyc(1, 0, 0, 0);

        // Lamp code 000 with a request: no walk.
        repeat (3) cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 0);

        // Illegal lamp pair: sticky fault until reset.
        cyc(1, 0, 1, 0);
        chk("fault_set", 32'(fault), 32'd1);
        repeat (4) cyc(0, 0, 1, 1);
        cyc(1, 0, 0, 1);
        chk("fault_held", 32'(fault), 32'd1);
        cyc(0, 0, 1, 0, 0);
        chk("fault_cleared", 32'(fault), 32'd0);

        // Randomized light sequences.
        for (int s = 0; s < 160; s++) begin
            int gl;
            int yl;
            int rl;
            gl = $urandom_range(1, 6);
            yl = $urandom_range(1, 3);
            rl = $urandom_range(2, 14);
            for (int i = 0; i < gl; i++) cyc(0, 0, 1, rbtn());
            for (int i = 0; i < yl; i++) cyc(0, 1, 0, rbtn());
            for (int i = 0; i < rl; i++) begin
                if ($urandom_range(0, 60) == 0) cyc(1, 0, 0, rbtn(), 0);
                else cyc(1, 0, 0, rbtn());
            end
            if ($urandom_range(0, 19) == 0) begin
                for (int i = 0; i < 3; i++) cyc(0, 0, 0, rbtn());
            end
            if ($urandom_range(0, 29) == 0) begin
                cyc(1, $urandom_range(0, 1), 1, rbtn());
                for (int i = 0; i < 3; i++) cyc(0, 0, 1, rbtn());
                cyc(0, 0, 1, 0, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ped_crossing.md
PED_CROSSING -- requirements
Module: ped_crossing

Interface
REQ-001 SHALL have parameter WALKTIMER, default 4: cycles of steady walk, legal range 1..15.
REQ-002 SHALL have parameter FLASHTIMER, default 3: cycles of flashing dont_walk, legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset; one clock, synchronous, active-low.
REQ-005 SHALL have ports red, yellow, green  input  1 each  vehicle lamp states from the upstream traffic-light controller.
REQ-006 SHALL have port ped_btn  input  1  pedestrian request, level, already synchronised.
REQ-007 SHALL have port walk  output  1  walk lamp.
REQ-008 SHALL have port dont_walk  output  1  don't-walk lamp.
REQ-009 SHALL have port req_pending  output  1  "wait" indicator, high while a request is latched.
REQ-010 SHALL have port fault  output  1  sticky illegal-lamp-code flag.
REQ-011 SHALL have port countdown  output  4  remaining flash cycles.

Function
REQ-012 SHALL register every output; no combinational input-to-output path.
REQ-013 SHALL use states IDLE, WAIT_RED, WALK, FLASH, CLEAR and FAULT.
REQ-014 SHALL detect red_rise as red=1 while the registered previous red=0.
REQ-015 SHALL latch a request on ped_btn=1 in IDLE, WAIT_RED, FLASH or CLEAR, and ignore it in WALK.
REQ-016 SHALL clear the request latch on entry to WALK.
REQ-017 SHALL transition IDLE->WAIT_RED when a request is latched and no red_rise occurs.
REQ-018 SHALL transition IDLE or WAIT_RED->WALK on red_rise with a latched request or ped_btn=1 in that same cycle; walk=1 from the next cycle.
REQ-019 SHALL hold WALK for exactly WALKTIMER cycles with walk=1, dont_walk=0, countdown=0.
REQ-020 SHALL hold FLASH for exactly FLASHTIMER cycles: walk=0; dont_walk toggles each cycle, starting at 1; countdown=FLASHTIMER-timer, running FLASHTIMER..1.
REQ-021 SHALL enter CLEAR after FLASH, with dont_walk=1 and countdown=0, and stay there until red=0, then go to IDLE, or to WAIT_RED if a request is latched; one walk per red phase.
REQ-022 SHALL, on red=0 during WALK or FLASH, abort to IDLE next cycle with walk=0, dont_walk=1 and no fault.
REQ-023 SHALL treat more than one of red/yellow/green high as illegal: enter FAULT, set fault=1, force walk=0 and dont_walk=1 until reset.
REQ-024 SHALL treat lamp code 000 as legal but no-red; no walk is granted.
REQ-025 SHALL use a 4-bit timer cleared on every state change; WALKTIMER+FLASHTIMER SHALL be configured below the upstream red duration, or REQ-022 applies.

Reset
REQ-026 SHALL, on rstn=0 at a clock edge, set state=IDLE, timer=0, previous red=0, request latch=0, walk=0, dont_walk=1, req_pending=0, fault=0, countdown=0.
REQ-027 SHALL let reset mid-WALK or mid-FLASH drop walk on the next edge, with no further output change until rstn=1.

Configuration
REQ-028 SHALL, with PED_COUNTDOWN_EN defined, drive countdown per REQ-020.
REQ-029 SHALL, without PED_COUNTDOWN_EN, tie countdown to 0 with the port list unchanged and all other behaviour identical.

Structure
REQ-030 SHALL place the state encoding and the default WALKTIMER/FLASHTIMER constants in package ped_pkg.
REQ-031 SHALL implement red edge detection in sub-module rise_detect (clk, rstn, d, rise).

Verification
REQ-032 SHALL cover: reset, then ped_btn pulse while green=1 -> req_pending=1, state WAIT_RED; at red_rise walk=1 next cycle for 4 cycles, then dont_walk 1,0,1 with countdown 3,2,1, then dont_walk=1.
REQ-033 SHALL cover: ped_btn=1 in the same cycle as red_rise from IDLE -> walk=1 next cycle and req_pending=0.
REQ-034 SHALL cover: red drops during the 2nd WALK cycle -> walk=0, dont_walk=1 next cycle, state IDLE, fault=0.
REQ-035 SHALL cover: red=1 and green=1 together -> fault=1 next cycle and held through lamp recovery until rstn=0.
REQ-036 SHALL cover: ped_btn pressed during FLASH -> no second walk in the same red; walk granted at the following red_rise.
REQ-037 SHALL cover: build without PED_COUNTDOWN_EN, rerun the REQ-032 scenario -> countdown=0 throughout, other outputs identical.
